// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: instruction type codes, bus widths,
// write-back NOP values, FSM states and byte-count helpers.
package mem_stage_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned INST_W     = 4;
  localparam int unsigned CNT_W      = 3;

  localparam logic [INST_W-1:0] INST_NOP = 4'd0;
  localparam logic [INST_W-1:0] INST_ALU = 4'd1;
  localparam logic [INST_W-1:0] INST_LB  = 4'd2;
  localparam logic [INST_W-1:0] INST_LH  = 4'd3;
  localparam logic [INST_W-1:0] INST_LW  = 4'd4;
  localparam logic [INST_W-1:0] INST_LBU = 4'd5;
  localparam logic [INST_W-1:0] INST_LHU = 4'd6;
  localparam logic [INST_W-1:0] INST_SB  = 4'd7;
  localparam logic [INST_W-1:0] INST_SH  = 4'd8;
  localparam logic [INST_W-1:0] INST_SW  = 4'd9;

  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic [REG_W-1:0]      ZERO_WORD     = 32'h0000_0000;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = 5'd0;

  localparam logic [CNT_W-1:0] BYTES_B = 3'd1;
  localparam logic [CNT_W-1:0] BYTES_H = 3'd2;
  localparam logic [CNT_W-1:0] BYTES_W = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_load(input logic [INST_W-1:0] t);
    return (t == INST_LB) || (t == INST_LH) || (t == INST_LW) ||
           (t == INST_LBU) || (t == INST_LHU);
  endfunction

  function automatic logic is_store(input logic [INST_W-1:0] t);
    return (t == INST_SB) || (t == INST_SH) || (t == INST_SW);
  endfunction

  function automatic logic [CNT_W-1:0] byte_count(input logic [INST_W-1:0] t);
    case (t)
      INST_LB, INST_LBU, INST_SB: return BYTES_B;
      INST_LH, INST_LHU, INST_SH: return BYTES_H;
      default:                    return BYTES_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled little-endian load value by load type.
module load_ext
  import mem_stage_pkg::*;
(
  input  logic [REG_W-1:0]  raw,
  input  logic [INST_W-1:0] inst_type,
  output logic [REG_W-1:0]  val
);

  always_comb begin
    val = raw;
    case (inst_type)
      INST_LB:  val = {{24{raw[7]}}, raw[7:0]};
      INST_LH:  val = {{16{raw[15]}}, raw[15:0]};
      INST_LBU: val = {24'h000000, raw[7:0]};
      INST_LHU: val = {16'h0000, raw[15:0]};
      default:  val = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through and serialises loads/stores over an
// 8-bit granted byte port, stalling the pipeline until the access completes.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rd_in,
  input  logic [REG_W-1:0]      rd_val_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [INST_W-1:0]     inst_type_in,
  input  logic [31:0]           mem_addr_in,
  input  logic [31:0]           mem_val_in,
  input  logic                  mem_grant_in,
  input  logic [7:0]            mem_din_in,
  output logic                  mem_req_out,
  output logic [31:0]           mem_a_out,
  output logic                  mem_wr_out,
  output logic [7:0]            mem_dout_out,
  output logic                  rd_out,
  output logic [REG_W-1:0]      rd_val_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [INST_W-1:0]     inst_type_out,
  output logic                  stallreq_from_mem
);

  state_e                  state, state_nxt;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [INST_W-1:0]       type_q, type_d;
  logic                    rd_q, rd_d;
  logic [REG_W-1:0]        rd_val_q, rd_val_d;
  logic [REG_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic                    issued_last_q, issued_last_d;
  logic [31:0]             buf_q, buf_d;
  logic [1:0]              slot;
  logic [REG_W-1:0]        ext_val;

  load_ext u_load_ext (
    .raw       (buf_q),
    .inst_type (type_q),
    .val       (ext_val)
  );

  // Byte slot of the read issued last cycle (cnt already advanced past it)
  assign slot = 2'(cnt_q - 3'd1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      type_q        <= INST_NOP;
      rd_q          <= WRITE_DISABLE;
      rd_val_q      <= ZERO_WORD;
      rd_addr_q     <= NOP_REG_ADDR;
      cnt_q         <= '0;
      n_q           <= '0;
      issued_last_q <= 1'b0;
      buf_q         <= 32'h0;
    end else begin
      addr_q        <= addr_d;
      data_q        <= data_d;
      type_q        <= type_d;
      rd_q          <= rd_d;
      rd_val_q      <= rd_val_d;
      rd_addr_q     <= rd_addr_d;
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      issued_last_q <= issued_last_d;
      buf_q         <= buf_d;
    end
  end

  always_comb begin
    state_nxt         = state;
    addr_d            = addr_q;
    data_d            = data_q;
    type_d            = type_q;
    rd_d              = rd_q;
    rd_val_d          = rd_val_q;
    rd_addr_d         = rd_addr_q;
    cnt_d             = cnt_q;
    n_d               = n_q;
    issued_last_d     = 1'b0;
    buf_d             = buf_q;
    mem_req_out       = 1'b0;
    mem_a_out         = 32'h0;
    mem_wr_out        = 1'b0;
    mem_dout_out      = 8'h00;
    stallreq_from_mem = 1'b0;
    rd_out            = rd_in;
    rd_val_out        = rd_val_in;
    rd_addr_out       = rd_addr_in;
    inst_type_out     = inst_type_in;

    if (issued_last_q) begin
      buf_d[{slot, 3'b000} +: 8] = mem_din_in;
    end

    case (state)
      IDLE: begin
        if (is_load(inst_type_in) || is_store(inst_type_in)) begin
          stallreq_from_mem = 1'b1;
          rd_out            = WRITE_DISABLE;
          rd_val_out        = ZERO_WORD;
          rd_addr_out       = NOP_REG_ADDR;
          inst_type_out     = INST_NOP;
          addr_d            = mem_addr_in;
          data_d            = mem_val_in;
          type_d            = inst_type_in;
          rd_d              = rd_in;
          rd_val_d          = rd_val_in;
          rd_addr_d         = rd_addr_in;
          n_d               = byte_count(inst_type_in);
          cnt_d             = '0;
          buf_d             = 32'h0;
          state_nxt         = BUSY;
        end
      end
      BUSY: begin
        stallreq_from_mem = 1'b1;
        rd_out            = WRITE_DISABLE;
        rd_val_out        = ZERO_WORD;
        rd_addr_out       = NOP_REG_ADDR;
        inst_type_out     = INST_NOP;
        mem_req_out       = 1'b1;
        mem_a_out         = addr_q + 32'(cnt_q);
        if (mem_grant_in) begin
          mem_wr_out    = is_store(type_q);
          mem_dout_out  = is_store(type_q) ? data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
          cnt_d         = cnt_q + 3'd1;
          issued_last_d = is_load(type_q);
          if (cnt_q == CNT_W'(n_q - 3'd1)) begin
            state_nxt = is_store(type_q) ? DONE : TAIL;
          end
        end
      end
      TAIL: begin
        stallreq_from_mem = 1'b1;
        rd_out            = WRITE_DISABLE;
        rd_val_out        = ZERO_WORD;
        rd_addr_out       = NOP_REG_ADDR;
        inst_type_out     = INST_NOP;
        state_nxt         = DONE;
      end
      DONE: begin
        rd_out        = is_load(type_q) ? rd_q : WRITE_DISABLE;
        rd_val_out    = is_load(type_q) ? ext_val : rd_val_q;
        rd_addr_out   = rd_addr_q;
        inst_type_out = type_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
